// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues word reads for incoming PCs, tags returned data with its PC
// and presents it in order to decode; redirect flushes buffered entries and drops in-flight reads.
module ifetch_buffer #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              pc_valid,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_ready,
   input  logic              redirect,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_err,
   input  logic              instr_ready
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [CW-1:0]     outstanding, discard, count;
   logic [PW-1:0]     pend_rd, pend_wr, rd_ptr, wr_ptr;
   logic [ADDR_W-1:0] pend_q   [DEPTH];
   logic [DATA_W-1:0] buf_data [DEPTH];
   logic [ADDR_W-1:0] buf_pc   [DEPTH];
   logic [DEPTH-1:0]  buf_err;

   logic [CW:0] occupancy;
   logic        credit, aligned, issue_ok, issue, err_acc;
   logic        resp, resp_keep, buf_we, pop, has_head;

   always_comb begin
      occupancy = {1'b0, outstanding} + {1'b0, count};
      credit    = occupancy < DEPTH_C;
      aligned   = (pc[1:0] == 2'b00);
      issue_ok  = nrst & pc_valid & credit & ~redirect;
      mem_req   = issue_ok & aligned;
      mem_addr  = mem_req ? pc : '0;
      issue     = mem_req & mem_gnt;
      // A misaligned PC only enters the buffer once every earlier read has drained,
      // so its error entry lands behind them in program order.
      err_acc   = issue_ok & ~aligned & (outstanding == '0) & (discard == '0);
      pc_ready  = issue | err_acc;

      resp      = mem_rvalid & (outstanding != '0);
      resp_keep = resp & (discard == '0) & ~redirect;
      buf_we    = resp_keep | err_acc;

      has_head    = (count != '0);
      instr_valid = nrst & has_head & ~redirect;
      pop         = instr_valid & instr_ready;
      instr       = has_head ? buf_data[rd_ptr] : '0;
      instr_pc    = has_head ? buf_pc[rd_ptr]   : '0;
      instr_err   = has_head & buf_err[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         pend_rd     <= '0;
         pend_wr     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect) begin
         // Everything still in flight (minus a response landing right now) must be dropped.
         discard     <= outstanding - CW'(resp);
         outstanding <= outstanding - CW'(resp);
         count       <= '0;
         pend_rd     <= '0;
         pend_wr     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(resp);
         if (issue)
            pend_wr <= pend_wr + PW'(1);
         if (resp) begin
            if (discard != '0)
               discard <= discard - CW'(1);
            else
               pend_rd <= pend_rd + PW'(1);
         end
         if (buf_we)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(buf_we) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (issue)
         pend_q[pend_wr] <= pc;
      if (buf_we) begin
         buf_data[wr_ptr] <= resp_keep ? mem_rdata : '0;
         buf_pc[wr_ptr]   <= resp_keep ? pend_q[pend_rd] : pc;
         buf_err[wr_ptr]  <= ~resp_keep;
      end
   end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomised bench for ifetch_buffer: a memory model answers grants in order, and a reference
// model of accepted fetches (since the last redirect) predicts every delivered instruction.
module tb_ifetch_buffer;

   localparam int DEPTH = 2;

   logic        clk, nrst;
   logic        pc_valid, pc_ready, redirect;
   logic [31:0] pc;
   logic        mem_req, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_rdata;
   logic        instr_valid, instr_err, instr_ready;
   logic [31:0] instr, instr_pc;

   ifetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .nrst(nrst),
      .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready), .redirect(redirect),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_err(instr_err), .instr_ready(instr_ready)
   );

   typedef struct {logic [31:0] pc; logic [31:0] data; logic err;} exp_t;
   typedef struct {logic [31:0] addr; int cyc; int epoch;} mreq_t;

   exp_t  exp_q[$];
   mreq_t mem_q[$];
   int    total = 0, bad = 0;
   int    cyc = 0, epoch = 0;
   bit    pop_now = 0, rst_now = 0, track = 0;
   int    first_gnt = -1, first_iv = -1;
   int    p_valid = 0, p_gnt = 0, p_rv = 0, p_ready = 0, p_redir = 0, p_mis = 0;
   logic [31:0] next_pc = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   function automatic bit chance(input int p);
      return $urandom_range(99) < p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever decode takes an instruction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (nrst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_instr", instr_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               pop_now = 1;
               check("instr_pc", instr_pc, e.pc);
               check("instr", instr, e.data);
               check("instr_err", instr_err, e.err);
            end
         end
      end
   end

   // One cycle of stimulus, then reference-model prediction of the handshake outputs.
   task automatic step();
      int live, buffered, occ;
      bit credit, aligned, e_req, e_prdy, e_iv;
      @(posedge clk);
      #1;
      cyc++;
      nrst        = !rst_now;
      pc_valid    = chance(p_valid);
      redirect    = chance(p_redir);
      instr_ready = chance(p_ready);
      mem_gnt     = chance(p_gnt);
      pc          = chance(p_mis) ? (next_pc | 32'($urandom_range(1, 3))) : next_pc;
      if (nrst && mem_q.size() > 0 && mem_q[0].cyc < cyc && chance(p_rv)) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_fn(mem_q[0].addr);
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
      end
      @(negedge clk);
      #1;
      if (!nrst) begin
         exp_q.delete();
         mem_q.delete();
         epoch++;
      end else begin
         live = 0;
         foreach (mem_q[i]) if (mem_q[i].epoch == epoch) live++;
         buffered = exp_q.size() + int'(pop_now) - live;
         occ      = mem_q.size() + buffered;
         credit   = occ < DEPTH;
         aligned  = (pc[1:0] == 2'b00);
         e_req    = pc_valid && aligned && credit && !redirect;
         e_prdy   = aligned ? (e_req && mem_gnt)
                            : (pc_valid && credit && !redirect && mem_q.size() == 0);
         e_iv     = (buffered > 0) && !redirect;
         check("mem_req", mem_req, e_req);
         check("pc_ready", pc_ready, e_prdy);
         check("instr_valid", instr_valid, e_iv);
         if (mem_req) check("mem_addr", mem_addr, pc);
         if (track && pc_ready && aligned && first_gnt < 0) first_gnt = cyc;
         if (track && instr_valid && first_iv < 0) first_iv = cyc;

         if (mem_rvalid) void'(mem_q.pop_front());
         if (redirect) begin
            exp_q.delete();
            epoch++;
            next_pc = $urandom & 32'h0000_fffc;
         end
         if (pc_ready) begin
            if (pc[1:0] == 2'b00) begin
               mem_q.push_back('{addr: pc, cyc: cyc, epoch: epoch});
               exp_q.push_back('{pc: pc, data: mem_fn(pc), err: 1'b0});
            end else begin
               exp_q.push_back('{pc: pc, data: 32'h0, err: 1'b1});
            end
            next_pc = {pc[31:2], 2'b00} + 32'd4;
         end
      end
      pop_now = 0;
   endtask

   task automatic knobs(input int v, input int g, input int rv, input int rd, input int rr,
                        input int m);
      p_valid = v; p_gnt = g; p_rv = rv; p_ready = rd; p_redir = rr; p_mis = m;
   endtask

   initial begin
      int n;
      nrst = 1'b0; pc_valid = 1'b0; pc = '0; redirect = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;

      rst_now = 1;
      step();
      step();
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_pc_ready", pc_ready, 1'b0);
      check("rst_instr_valid", instr_valid, 1'b0);
      check("rst_instr_err", instr_err, 1'b0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      rst_now = 0;

      // Streaming from 0x0 with immediate grant and one-cycle response.
      next_pc = 32'h0;
      knobs(100, 100, 100, 100, 0, 0);
      track = 1;
      repeat (12) step();
      track = 0;
      check("first_valid_latency", first_iv - first_gnt, 2);

      // Backpressure until the buffer fills, then a single pop.
      knobs(100, 100, 100, 0, 0, 0);
      repeat (8) step();
      check("full_instr_valid", instr_valid, 1'b1);
      check("full_mem_req", mem_req, 1'b0);
      knobs(100, 100, 100, 100, 0, 0);
      step();
      knobs(100, 100, 100, 0, 0, 0);
      repeat (3) step();

      // Reset while the buffer is full.
      rst_now = 1;
      step();
      rst_now = 0;
      knobs(0, 100, 100, 0, 0, 0);
      step();
      check("post_rst_instr_valid", instr_valid, 1'b0);
      check("post_rst_mem_req", mem_req, 1'b0);

      // Redirect with two reads outstanding, then refetch from 0x100.
      next_pc = 32'h10;
      knobs(100, 100, 0, 100, 0, 0);
      repeat (2) step();
      knobs(0, 100, 0, 100, 100, 0);
      step();
      next_pc = 32'h100;
      knobs(100, 100, 100, 100, 0, 0);
      repeat (10) step();

      // Redirect coincident with a response.
      knobs(0, 100, 100, 100, 0, 0);
      repeat (6) step();
      next_pc = 32'h20;
      knobs(100, 100, 0, 100, 0, 0);
      repeat (2) step();
      knobs(0, 100, 100, 100, 100, 0);
      step();
      next_pc = 32'h200;
      knobs(100, 100, 100, 100, 0, 0);
      repeat (10) step();

      // Misaligned fetch behind an outstanding read.
      knobs(0, 100, 100, 100, 0, 0);
      repeat (6) step();
      next_pc = 32'h0;
      knobs(100, 100, 0, 100, 0, 0);
      step();
      knobs(100, 100, 0, 100, 0, 100);
      repeat (4) step();
      knobs(100, 100, 100, 100, 0, 100);
      step();
      knobs(0, 100, 100, 100, 0, 0);
      repeat (6) step();

      // Randomised mixes.
      for (int blk = 0; blk < 8; blk++) begin
         knobs($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(20, 100),
               $urandom_range(10, 100), $urandom_range(0, 8), $urandom_range(0, 15));
         repeat (400) step();
      end

      // Drain with a bounded wait.
      knobs(0, 100, 100, 100, 0, 0);
      n = 0;
      while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 100) begin
         step();
         n++;
      end
      check("drain_left_expected", exp_q.size(), 0);
      check("drain_left_inflight", mem_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Consumer end of the next-PC stream. Accepts fetch addresses from the PC generator and issues word reads on the instruction-memory request/grant/response bus.
- Tags each returned word with its PC, queues it in a small in-order buffer and presents it to decode with a valid/ready handshake.
- `redirect` (taken branch or jump resolved downstream) flushes the buffer and drops responses still in flight.

Parameters:
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction word width
- DEPTH, 2, instruction buffer entries; also the maximum number of outstanding memory reads (power of 2, ≥2)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- pc_valid  in  1  fetch address offered
- pc  in  ADDR_W  fetch address
- pc_ready  out  1  address accepted this cycle (handshake complete)
- redirect  in  1  flush: discard buffered and in-flight fetches
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address, word aligned
- mem_gnt  in  1  request accepted by memory
- mem_rvalid  in  1  read data valid; in order, ≥1 cycle after its grant
- mem_rdata  in  DATA_W  read data
- instr_valid  out  1  buffer head valid
- instr  out  DATA_W  head instruction
- instr_pc  out  ADDR_W  PC of head instruction
- instr_err  out  1  head entry is a misaligned-fetch error (instr = 0)
- instr_ready  in  1  decode accepts head

Behaviour:
- State: `outstanding` (0..DEPTH), `discard` (0..DEPTH), `count` (0..DEPTH), pending-PC queue of DEPTH entries, entry buffer of DEPTH entries {data, pc, err}, circular read/write pointers.
- Reset: all counters and pointers 0. `mem_req`, `pc_ready`, `instr_valid` and `instr_err` are 0. `instr`, `instr_pc` and `mem_addr` are 0.
- Credit rule: `credit = (outstanding + count < DEPTH)`. A pop in the same cycle is not counted.
- Aligned issue (`pc[1:0] == 0`):
  - `mem_req = pc_valid & credit & ~redirect`
  - `mem_addr = pc`
  - `pc_ready = mem_req & mem_gnt`
  - On handshake: push `pc` to the pending queue and increment `outstanding`.
  - `mem_req` may be withdrawn while ungranted.
- Misaligned issue (`pc[1:0] != 0`):
  - No memory request is made.
  - When `pc_valid & credit & ~redirect & outstanding == 0 & discard == 0`: `pc_ready = 1` and write entry {0, pc, err = 1} into the buffer.
  - Otherwise `pc_ready = 0`.
- Response handling when `mem_rvalid`:
  - If `discard > 0`: drop the data, decrement `discard` and `outstanding`; the pending queue is untouched.
  - Otherwise: write {mem_rdata, pending head, 0} into the buffer, pop the pending queue, decrement `outstanding`.
  - `mem_rvalid` with `outstanding == 0` is a protocol violation and is ignored.
- Output: show-ahead.
  - `instr_valid = (count != 0) & ~redirect`; `instr`, `instr_pc` and `instr_err` come from the buffer head.
  - Pop on `instr_valid & instr_ready`.
  - Write and pop in the same cycle leave `count` unchanged.
- Latency: grant in cycle N, rvalid in cycle N+k, `instr_valid` in cycle N+k+1 (minimum 2 cycles grant-to-valid).
- Redirect cycle:
  - `mem_req`, `pc_ready` and `instr_valid` are forced 0.
  - Next state: `count = 0`, pointers cleared, pending queue cleared.
  - `discard = outstanding − (mem_rvalid ? 1 : 0)`, where `outstanding` is the pre-redirect value. The rvalid arriving in the redirect cycle is itself dropped.
  - If `discard > 0` from an earlier redirect, the new redirect's `outstanding` is already ≥ `discard`, so the same formula holds.
- Buffer full (`count == DEPTH`): no credit, so a full buffer never overflows.
- Empty buffer: `instr_valid = 0`; `instr_ready` is ignored.
- Pointers wrap modulo DEPTH.
- Mid-operation reset: behaves as power-on reset. Outstanding memory responses after reset are the memory's responsibility (it must reset with the same `nrst`).

Test Plan:
- Streaming: pc 0x0, 0x4, 0x8, 0xC with `mem_gnt = 1` and rvalid 1 cycle after grant, `instr_ready = 1`:
  - instr_pc 0x0, 0x4, 0x8, 0xC in order, with matching rdata.
  - First `instr_valid` exactly 2 cycles after the first grant.
- Backpressure: `instr_ready = 0`, DEPTH = 2:
  - After 2 responses, `count = 2` and `mem_req` stays 0 with `pc_valid = 1`.
  - Raising `instr_ready` for 1 cycle pops 0x0; credit returns next cycle.
- Redirect with 2 outstanding:
  - 2 grants (0x10, 0x14), `redirect` the next cycle, then request 0x100.
  - Both old responses are dropped (`discard` 2→0).
  - First `instr_valid` shows instr_pc = 0x100 with the third rdata.
- Redirect coincident with rvalid, 2 outstanding:
  - That response is dropped and `discard = 1`; the next rvalid is dropped.
  - The following response is delivered.
- Misaligned: pc = 0x6 while 1 read is outstanding:
  - `pc_ready` stays 0 until the response returns; then the error entry is accepted.
  - `instr_err = 1` with instr_pc = 0x6, following the earlier instruction.
- Reset mid-stream: `nrst = 0` for 1 cycle with `count = 2`:
  - Next cycle `instr_valid = 0`, `mem_req = 0`, all counters 0.
